// File: rtl/sblk_pkg.sv
// Shared definitions for the superblock activation feeder: element width default and FSM states.
package sblk_pkg;

    localparam int WID_ACT_DEF = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } sblk_state_t;

endpackage

// File: rtl/sblk_act_fifo.sv
// Synchronous FIFO for packed activation words; a write is allowed while full if a pop happens in the same cycle.
module sblk_act_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk_l,
    input  logic                     rst,
    input  logic                     i_wr,
    input  logic [WIDTH-1:0]         i_wdata,
    input  logic                     i_rd,
    output logic [WIDTH-1:0]         o_rdata,
    output logic                     o_full,
    output logic                     o_empty,
    output logic [$clog2(DEPTH):0]   o_count
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             w_wr_en;
    logic             w_rd_en;

    assign o_full  = (r_count == (AW+1)'(DEPTH));
    assign o_empty = (r_count == '0);
    assign o_count = r_count;
    assign o_rdata = r_mem[r_rd_ptr];

    assign w_rd_en = i_rd && !o_empty;
    assign w_wr_en = i_wr && (!o_full || w_rd_en);

    always_ff @(posedge clk_l) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr] <= i_wdata;
        end
    end

    // Pointers are exactly AW bits wide, so DEPTH being a power of two makes them wrap for free.
    always_ff @(posedge clk_l) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({w_wr_en, w_rd_en})
                2'b10:   r_count <= r_count + (AW+1)'(1);
                2'b01:   r_count <= r_count - (AW+1)'(1);
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/sblk_act_feeder.sv
// Packs pairs of upstream activation elements into double-width words and feeds them to the superblock.
// Optional feature: define SBLK_ACT_FEEDER_ZPAD_EN to accept odd bursts, zero-padding the final lone element.
module sblk_act_feeder
    import sblk_pkg::*;
#(
    parameter int WID_ACT    = sblk_pkg::WID_ACT_DEF,
    parameter int WID_LEN    = 10,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                   clk_l,
    input  logic                   rst,
    input  logic                   start,
    input  logic [WID_LEN-1:0]     burst_len,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    input  logic [WID_ACT-1:0]     src_data,
    input  logic                   src_vld,
    output logic                   src_rdy,
    output logic [2*WID_ACT-1:0]   act_data_in,
    output logic                   act_data_in_vld,
    input  logic                   act_data_in_req
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    sblk_state_t          r_state;
    sblk_state_t          w_state_nxt;
    logic [WID_LEN-1:0]   r_remain;
    logic [WID_ACT-1:0]   r_lo;
    logic                 r_half;
    logic                 r_done;
    logic                 r_err;
    logic                 w_done_nxt;
    logic                 w_err_nxt;
    logic                 w_odd_ok;
    logic                 w_lone;
    logic                 w_accept;
    logic                 w_wr;
    logic                 w_pop;
    logic                 w_full;
    logic                 w_empty;
    logic [CW-1:0]        w_count;
    logic [2*WID_ACT-1:0] w_wdata;
    logic [2*WID_ACT-1:0] w_head;

`ifdef SBLK_ACT_FEEDER_ZPAD_EN
    assign w_odd_ok = 1'b1;
    assign w_lone   = !r_half && (r_remain == WID_LEN'(1));
`else
    assign w_odd_ok = 1'b0;
    assign w_lone   = 1'b0;
`endif

    assign busy            = (r_state != ST_IDLE);
    assign done            = r_done;
    assign err             = r_err;
    assign src_rdy         = (r_state == ST_RUN) && (r_remain != '0) && !w_full;
    assign w_accept        = src_vld && src_rdy;
    assign w_wr            = w_accept && (r_half || w_lone);
    assign w_wdata         = r_half ? {src_data, r_lo} : {{WID_ACT{1'b0}}, src_data};
    assign w_pop           = !w_empty && act_data_in_req;
    assign act_data_in_vld = w_pop;
    assign act_data_in     = w_empty ? '0 : w_head;

    sblk_act_fifo #(
        .WIDTH (2*WID_ACT),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_l   (clk_l),
        .rst     (rst),
        .i_wr    (w_wr),
        .i_wdata (w_wdata),
        .i_rd    (w_pop),
        .o_rdata (w_head),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_count (w_count)
    );

    always_ff @(posedge clk_l) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_done_nxt  = 1'b0;
        w_err_nxt   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (start) begin
                    if (burst_len == '0)                 w_done_nxt  = 1'b1;
                    else if (burst_len[0] && !w_odd_ok)  w_err_nxt   = 1'b1;
                    else                                 w_state_nxt = ST_RUN;
                end
            end
            ST_RUN: begin
                if (w_accept && (r_remain == WID_LEN'(1))) w_state_nxt = ST_DRAIN;
            end
            ST_DRAIN: begin
                // Leave as the final word pops so done lands exactly one cycle after the last beat.
                if (w_empty || (w_pop && (w_count == CW'(1)))) begin
                    w_state_nxt = ST_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_l) begin
        if (rst) begin
            r_remain <= '0;
            r_lo     <= '0;
            r_half   <= 1'b0;
            r_done   <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_done <= w_done_nxt;
            r_err  <= w_err_nxt;
            if ((r_state == ST_IDLE) && (w_state_nxt == ST_RUN)) begin
                r_remain <= burst_len;
                r_half   <= 1'b0;
            end else if (w_accept) begin
                r_remain <= r_remain - WID_LEN'(1);
                if (w_wr) begin
                    r_half <= 1'b0;
                end else begin
                    r_half <= 1'b1;
                    r_lo   <= src_data;
                end
            end
        end
    end

endmodule

// File: tb/tb_sblk_act_feeder.sv
// Randomized self-checking bench for sblk_act_feeder against a pair-packing reference model.
module tb_sblk_act_feeder;

    localparam int WA    = 16;
    localparam int WL    = 10;
    localparam int DEPTH = 4;

`ifdef SBLK_ACT_FEEDER_ZPAD_EN
    localparam bit ZPAD = 1'b1;
`else
    localparam bit ZPAD = 1'b0;
`endif

    logic            clk_l = 1'b0;
    logic            rst = 1'b1;
    logic            start = 1'b0;
    logic [WL-1:0]   burst_len = '0;
    logic            busy, done, err;
    logic [WA-1:0]   src_data = '0;
    logic            src_vld = 1'b0;
    logic            src_rdy;
    logic [2*WA-1:0] act_data_in;
    logic            act_data_in_vld;
    logic            act_data_in_req = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    logic [WA-1:0]   elems[$];
    logic [2*WA-1:0] exp_q[$];
    logic [2*WA-1:0] obs_q[$];
    int done_cnt, err_cnt, done_cyc, err_cyc, last_beat_cyc, start_cyc;
    int acc_cnt, acc_snap;
    bit rdy_snap, timed_out;

    sblk_act_feeder #(
        .WID_ACT    (WA),
        .WID_LEN    (WL),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_l           (clk_l),
        .rst             (rst),
        .start           (start),
        .burst_len       (burst_len),
        .busy            (busy),
        .done            (done),
        .err             (err),
        .src_data        (src_data),
        .src_vld         (src_vld),
        .src_rdy         (src_rdy),
        .act_data_in     (act_data_in),
        .act_data_in_vld (act_data_in_vld),
        .act_data_in_req (act_data_in_req)
    );

    always #5 clk_l = ~clk_l;
    always @(posedge clk_l) cyc <= cyc + 1;

    always @(negedge clk_l) begin
        if (act_data_in_vld) begin
            obs_q.push_back(act_data_in);
            last_beat_cyc = cyc;
        end
        if (done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (err) begin
            err_cnt++;
            err_cyc = cyc;
        end
    end

    // Reference model: consecutive elements pair up low-half first; a lone trailing element is zero-padded.
    function automatic void build_expected(input int len);
        exp_q.delete();
        if (len % 2 == 1 && !ZPAD) return;
        for (int i = 0; i + 1 < len; i += 2) exp_q.push_back({elems[i+1], elems[i]});
        if (len % 2 == 1) exp_q.push_back({{WA{1'b0}}, elems[len-1]});
    endfunction

    function automatic void make_elems(input int len);
        elems.delete();
        for (int i = 0; i < len; i++) elems.push_back(WA'($urandom));
    endfunction

    task automatic clear_obs();
        obs_q.delete();
        done_cnt = 0; err_cnt = 0; done_cyc = -1; err_cyc = -1; last_beat_cyc = -1;
    endtask

    task automatic drive_burst(input int len, input int req_pct, input int vld_pct,
                               input int req_off, input bit extra_start, input int max_cyc);
        int idx = 0;
        int n = 0;
        bit fin = 0;
        clear_obs();
        acc_cnt = 0; acc_snap = -1; rdy_snap = 1'b1; timed_out = 1'b0;
        @(posedge clk_l); #1;
        start = 1'b1; burst_len = WL'(len); src_vld = 1'b0; act_data_in_req = 1'b0;
        @(negedge clk_l);
        start_cyc = cyc;
        @(posedge clk_l); #1;
        start = 1'b0;
        while (!fin && n < max_cyc) begin
            src_vld  = (idx < elems.size()) && ($urandom_range(99) < vld_pct);
            src_data = (idx < elems.size()) ? elems[idx] : WA'($urandom);
            act_data_in_req = (n >= req_off) && ($urandom_range(99) < req_pct);
            start     = extra_start && (n == 3);
            burst_len = extra_start ? WL'(8) : WL'(len);
            @(negedge clk_l);
            if (src_vld && src_rdy) begin
                idx++;
                acc_cnt++;
            end
            if (n == req_off - 1) begin
                rdy_snap = src_rdy;
                acc_snap = acc_cnt;
            end
            if (done || err) fin = 1;
            n++;
            @(posedge clk_l); #1;
        end
        start = 1'b0; src_vld = 1'b0;
        if (!fin) timed_out = 1'b1;
        act_data_in_req = 1'b1;
        repeat (3) @(posedge clk_l);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; act_data_in_req = 1'b1; src_vld = 1'b1; start = 1'b1; burst_len = WL'(4);
        repeat (3) @(posedge clk_l);
        @(negedge clk_l);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
        checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
        checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
        checks++; if (src_rdy !== 1'b0) begin errors++; $display("FAIL reset_src_rdy: got %b want 0", src_rdy); end
        checks++; if (act_data_in_vld !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b want 0", act_data_in_vld); end
        checks++; if (act_data_in !== '0) begin errors++; $display("FAIL reset_data: got %h want 0", act_data_in); end
        @(posedge clk_l); #1;
        rst = 1'b0; start = 1'b0; src_vld = 1'b0; act_data_in_req = 1'b0;
        repeat (2) @(posedge clk_l);
        #1;
    endtask

    task automatic test_basic();
        elems.delete();
        for (int i = 1; i <= 4; i++) elems.push_back(WA'(i));
        build_expected(4);
        drive_burst(4, 100, 100, 0, 1'b0, 200);
        checks++; if (timed_out) begin errors++; $display("FAIL basic_timeout: got timeout want done"); end
        checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL basic_beats: got %0d want 2", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < 2; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL basic_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL basic_done_cnt: got %0d want 1", done_cnt); end
        checks++; if (done_cyc != last_beat_cyc + 1) begin errors++; $display("FAIL basic_done_time: got %0d want %0d", done_cyc, last_beat_cyc + 1); end
    endtask

    task automatic test_backpressure();
        make_elems(16);
        build_expected(16);
        drive_burst(16, 100, 100, 20, 1'b0, 400);
        checks++; if (rdy_snap !== 1'b0) begin errors++; $display("FAIL bp_src_rdy: got %b want 0", rdy_snap); end
        checks++; if (acc_snap != 2*DEPTH) begin errors++; $display("FAIL bp_accepted: got %0d want %0d", acc_snap, 2*DEPTH); end
        checks++; if (obs_q.size() != 8) begin errors++; $display("FAIL bp_beats: got %0d want 8", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL bp_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL bp_done_cnt: got %0d want 1", done_cnt); end
    endtask

    task automatic test_zero_and_busy();
        elems.delete();
        drive_burst(0, 100, 100, 0, 1'b0, 20);
        checks++; if (done_cyc != start_cyc + 1) begin errors++; $display("FAIL zero_done_time: got %0d want %0d", done_cyc, start_cyc + 1); end
        checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL zero_beats: got %0d want 0", obs_q.size()); end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL zero_done_cnt: got %0d want 1", done_cnt); end
        make_elems(4);
        build_expected(4);
        drive_burst(4, 100, 100, 0, 1'b1, 200);
        checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL busy_beats: got %0d want 2", obs_q.size()); end
        for (int i = 0; i < obs_q.size() && i < 2; i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL busy_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL busy_done_cnt: got %0d want 1", done_cnt); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL busy_after: got %b want 0", busy); end
    endtask

    task automatic test_odd();
        elems.delete();
        elems.push_back(WA'('hA)); elems.push_back(WA'('hB)); elems.push_back(WA'('hC));
        build_expected(3);
        drive_burst(3, 100, 100, 0, 1'b0, 200);
        checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL odd_beats: got %0d want %0d", obs_q.size(), exp_q.size()); end
        for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
            checks++;
            if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL odd_word%0d: got %h want %h", i, obs_q[i], exp_q[i]); end
        end
        if (ZPAD) begin
            checks++; if (done_cnt != 1 || err_cnt != 0) begin errors++; $display("FAIL odd_zpad_flags: got done=%0d err=%0d want 1/0", done_cnt, err_cnt); end
        end else begin
            checks++; if (err_cnt != 1 || done_cnt != 0) begin errors++; $display("FAIL odd_err_flags: got err=%0d done=%0d want 1/0", err_cnt, done_cnt); end
            checks++; if (err_cyc != start_cyc + 1) begin errors++; $display("FAIL odd_err_time: got %0d want %0d", err_cyc, start_cyc + 1); end
        end
    endtask

    task automatic test_reset_mid();
        int n = 0;
        make_elems(16);
        clear_obs();
        @(posedge clk_l); #1;
        start = 1'b1; burst_len = WL'(16);
        @(posedge clk_l); #1;
        start = 1'b0;
        while (obs_q.size() < 2 && n < 100) begin
            src_vld = (n < 16); src_data = elems[n % 16]; act_data_in_req = 1'b1;
            @(posedge clk_l); #1;
            n++;
        end
        checks++; if (obs_q.size() != 2) begin errors++; $display("FAIL rstmid_pre_beats: got %0d want 2", obs_q.size()); end
        rst = 1'b1; act_data_in_req = 1'b0; src_vld = 1'b1;
        @(negedge clk_l);
        @(negedge clk_l);
        checks++;
        if ({busy, done, err, src_rdy, act_data_in_vld} !== 5'b0 || act_data_in !== '0) begin
            errors++;
            $display("FAIL rstmid_outputs: got busy=%b done=%b err=%b rdy=%b vld=%b data=%h want all 0",
                     busy, done, err, src_rdy, act_data_in_vld, act_data_in);
        end
        @(posedge clk_l); #1;
        rst = 1'b0; act_data_in_req = 1'b1;
        clear_obs();
        repeat (12) @(posedge clk_l);
        #1;
        src_vld = 1'b0;
        checks++; if (obs_q.size() != 0 || done_cnt != 0) begin errors++; $display("FAIL rstmid_quiet: got beats=%0d done=%0d want 0/0", obs_q.size(), done_cnt); end
        make_elems(2);
        build_expected(2);
        drive_burst(2, 100, 100, 0, 1'b0, 100);
        checks++;
        if (obs_q.size() != 1 || obs_q[0] !== exp_q[0]) begin
            errors++;
            $display("FAIL rstmid_new_burst: got %0d beats first=%h want 1 beat %h", obs_q.size(),
                     (obs_q.size() > 0) ? obs_q[0] : '0, exp_q[0]);
        end
        checks++; if (done_cnt != 1) begin errors++; $display("FAIL rstmid_done: got %0d want 1", done_cnt); end
    endtask

    task automatic test_random();
        for (int b = 0; b < 8; b++) begin
            int len;
            len = ZPAD ? $urandom_range(25, 1) : 2 * $urandom_range(12, 1);
            make_elems(len);
            build_expected(len);
            drive_burst(len, $urandom_range(100, 20), $urandom_range(100, 30), $urandom_range(6, 0), 1'b0, 3000);
            checks++; if (timed_out) begin errors++; $display("FAIL rand%0d_timeout: got timeout want done", b); end
            checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand%0d_beats: got %0d want %0d", b, obs_q.size(), exp_q.size()); end
            for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
                checks++;
                if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL rand%0d_word%0d: got %h want %h", b, i, obs_q[i], exp_q[i]); end
            end
            checks++; if (done_cnt != 1 || done_cyc != last_beat_cyc + 1) begin
                errors++; $display("FAIL rand%0d_done: got cnt=%0d at %0d want 1 at %0d", b, done_cnt, done_cyc, last_beat_cyc + 1);
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_zero_and_busy();
        test_odd();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got no completion want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
